// File: rtl/dcache_line_ram.sv
// D-cache data array: byte-lane CPU port plus refill and eviction bursts.
// Define DCACHE_CWF_EN to start refill at fill_ofs (critical word first).
module dcache_line_ram #(
  parameter int IDX_W = 7,
  parameter int OFS_W = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   a_en,
  input  logic [3:0]             a_wen,
  input  logic [IDX_W+OFS_W-1:0] a_addr,
  input  logic [31:0]            a_din,
  output logic [31:0]            a_dout,
  output logic                   a_stall,
  input  logic                   fill_start,
  input  logic [IDX_W-1:0]       fill_idx,
  input  logic [OFS_W-1:0]       fill_ofs,
  input  logic                   fill_valid,
  input  logic [31:0]            fill_data,
  output logic                   fill_ready,
  output logic                   fill_done,
  input  logic                   ev_start,
  input  logic [IDX_W-1:0]       ev_idx,
  output logic                   ev_valid,
  output logic [31:0]            ev_data,
  output logic                   ev_last,
  input  logic                   ev_ready
);

  localparam int AW    = IDX_W + OFS_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EVICT
  } state_e;

  state_e           state_q, state_d;
  logic [OFS_W-1:0] cnt_q, cnt_d;
  logic [OFS_W-1:0] bcnt_q, bcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_done_q, rd_done_d;
  logic [31:0]      a_dout_q, a_dout_d;
  logic [31:0]      ev_data_q, ev_data_d;
  logic             ev_valid_q, ev_valid_d;
  logic             ev_last_q, ev_last_d;
  logic             fill_done_q, fill_done_d;

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    m_addr;
  logic [3:0]       m_we;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata;
  logic [31:0]      merged;
  logic             cpu_acc;
  logic             ev_hs;
  logic             rd_en;
  logic [OFS_W-1:0] ofs_start;

`ifdef DCACHE_CWF_EN
  assign ofs_start = fill_ofs;
`else
  logic unused_ofs;
  assign unused_ofs = ^fill_ofs;
  assign ofs_start  = '0;
`endif

  assign a_stall = (state_q != IDLE)
                 | fill_start | ev_start;
  assign cpu_acc = a_en & ~a_stall & resetn;
  assign ev_hs   = ev_valid_q & ev_ready;
  assign rd_en   = (state_q == EVICT)
                 & ~rd_done_q
                 & (~ev_valid_q | ev_ready);
  assign m_rdata = mem[m_addr];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = a_wen[b]
        ? a_din[8*b +: 8]
        : m_rdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    idx_d       = idx_q;
    rd_done_d   = rd_done_q;
    a_dout_d    = a_dout_q;
    ev_data_d   = ev_data_q;
    ev_valid_d  = ev_valid_q;
    ev_last_d   = ev_last_q;
    fill_done_d = 1'b0;
    m_addr      = a_addr;
    m_we        = '0;
    m_wdata     = merged;
    unique case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d   = EVICT;
          idx_d     = ev_idx;
          cnt_d     = '0;
          rd_done_d = 1'b0;
        end else if (fill_start) begin
          state_d = FILL;
          idx_d   = fill_idx;
          cnt_d   = ofs_start;
          bcnt_d  = '0;
        end else if (cpu_acc) begin
          m_we     = a_wen;
          a_dout_d = merged;
        end
      end
      FILL: begin
        m_addr  = {idx_q, cnt_q};
        m_wdata = fill_data;
        if (fill_valid) begin
          m_we   = 4'hf;
          cnt_d  = cnt_q + 1'b1;
          bcnt_d = bcnt_q + 1'b1;
          if (&bcnt_q) begin
            state_d     = IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      EVICT: begin
        m_addr = {idx_q, cnt_q};
        if (rd_en) begin
          ev_data_d  = m_rdata;
          ev_valid_d = 1'b1;
          ev_last_d  = &cnt_q;
          cnt_d      = cnt_q + 1'b1;
          rd_done_d  = &cnt_q;
        end else if (ev_hs) begin
          ev_valid_d = 1'b0;
          ev_last_d  = 1'b0;
        end
        if (ev_hs && ev_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      idx_q       <= '0;
      rd_done_q   <= 1'b0;
      a_dout_q    <= '0;
      ev_data_q   <= '0;
      ev_valid_q  <= 1'b0;
      ev_last_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      rd_done_q   <= rd_done_d;
      a_dout_q    <= a_dout_d;
      ev_data_q   <= ev_data_d;
      ev_valid_q  <= ev_valid_d;
      ev_last_q   <= ev_last_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Array contents survive reset; only lanes with an enable are written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m_we[b]) begin
        mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  assign a_dout     = a_dout_q;
  assign ev_data    = ev_data_q;
  assign ev_valid   = ev_valid_q;
  assign ev_last    = ev_last_q;
  assign fill_ready = (state_q == FILL);
  assign fill_done  = fill_done_q;

endmodule

// File: doc/dcache_line_ram.md
# dcache_line_ram

- Parametrised data-array block for the data cache.
- Holds 2^IDX_W lines of 2^OFS_W 32-bit words, with per-byte write enables on the CPU port.
- Adds two line-burst engines on top of the single RAM port: refill, with optional critical-word-first, and eviction readout with a valid/ready handshake. Both take priority over CPU access.
- Sits between the D-cache controller (CPU port, stall) and the bus interface unit (refill/eviction streams).

## Interface
- IDX_W, 7, line index bits; 2^IDX_W lines.
- OFS_W, 3, word-offset bits; 2^OFS_W words per line; must be ≥1.
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- a_en  in  1  CPU access request.
- a_wen  in  4  byte write enables; bit n writes bits 8n+7:8n.
- a_addr  in  IDX_W+OFS_W  word address {index, offset}.
- a_din  in  32  CPU write data.
- a_dout  out  32  registered CPU read data.
- a_stall  out  1  CPU access not accepted this cycle.
- fill_start  in  1  begin line refill.
- fill_idx  in  IDX_W  line to refill.
- fill_ofs  in  OFS_W  first word offset of the refill burst.
- fill_valid  in  1  fill_data valid.
- fill_data  in  32  refill word.
- fill_ready  out  1  refill word accepted when valid.
- fill_done  out  1  one-cycle pulse after the last refill word is written.
- ev_start  in  1  begin line eviction.
- ev_idx  in  IDX_W  line to evict.
- ev_valid  out  1  ev_data valid.
- ev_data  out  32  evicted word, offsets 0 to 2^OFS_W−1 in order.
- ev_last  out  1  qualifies the final eviction word.
- ev_ready  in  1  consumer accepts ev_data.

## Operation
- Single RAM of 2^(IDX_W+OFS_W) × 32 bits, four byte lanes. Contents are not reset.
- FSM states: IDLE, FILL, EVICT.
- **IDLE**
  - ev_start=1 → EVICT; ev_start wins over a simultaneous fill_start, which is dropped and must be reissued after eviction ends.
  - Otherwise fill_start=1 → FILL.
  - Otherwise CPU access proceeds.
- **CPU port** (accepted when a_en=1 and a_stall=0)
  - Enabled a_wen bytes are written.
  - a_dout loads the word at a_addr, write-first: written bytes show a_din, the rest show old contents.
  - a_dout holds until the next accepted CPU access.
- **a_stall** = (state≠IDLE) | ((fill_start|ev_start) & state==IDLE).
  - While stalled, CPU writes are suppressed.
- **FILL**
  - fill_ready=1 throughout.
  - Word counter cnt (OFS_W bits) loads fill_ofs at start.
  - Each fill_valid beat writes fill_data (all 4 bytes) to {fill_idx_q, cnt}; cnt increments mod 2^OFS_W, so the burst wraps past the line end.
  - Beat counter counts 2^OFS_W beats; the last beat → IDLE and fill_done pulses the next cycle.
  - fill_idx is latched at start; fill_ofs/fill_idx changes mid-burst are ignored.
- **EVICT**
  - ev_idx is latched; read counter starts at 0.
  - A RAM read of {ev_idx_q, rcnt} issues when no word is outstanding or ev_valid&ev_ready.
  - ev_data is the registered read output; it holds stable while ev_valid=1 and ev_ready=0.
  - ev_last=1 with the word at offset 2^OFS_W−1.
  - The handshake on ev_last → IDLE; ev_valid drops the next cycle unless a new eviction starts.
- **Reset (async, any state)**
  - State → IDLE; counters → 0.
  - a_dout=0, ev_data=0, ev_valid=0, ev_last=0, fill_ready=0, fill_done=0, a_stall=0.
  - An in-flight burst is abandoned; partially refilled lines keep the words already written.

## Timing
- CPU read latency: 1 cycle (a_dout valid the cycle after acceptance).
- Refill: 1 word/cycle max.
  - The first refill beat may coincide with the cycle after fill_start.
  - Minimum FILL duration: 2^OFS_W cycles.
  - fill_done is asserted 1 cycle after the last beat; the CPU may issue in the fill_done cycle.
- Eviction:
  - First ev_valid 2 cycles after ev_start.
  - Sustains 1 word/cycle with ev_ready held high.
  - No bubbles are inserted after backpressure releases.
- Start requests are sampled only in IDLE; starts asserted in FILL/EVICT are ignored.

## Configuration
- DCACHE_CWF_EN defined: refill begins at fill_ofs and wraps (critical word first).
- DCACHE_CWF_EN undefined: fill_ofs is ignored; refill always begins at offset 0 and ends at 2^OFS_W−1. The port remains present.

## Test plan
- CPU write then read:
  - Write a_addr=0x005, a_wen=4'b0101, a_din=0xAABBCCDD over old 0x11223344.
  - Next-cycle read → a_dout=0x11BB33DD.
  - Same-cycle read/write → write-first value.
- Refill, CWF on (OFS_W=3):
  - fill_idx=2, fill_ofs=5, data 0..7.
  - Offsets 5,6,7,0,1,2,3,4 hold 0..7.
  - fill_done pulses once; a_stall is high from the start cycle to the last beat.
- Refill, CWF off:
  - Same stimulus → offset k holds k.
- Eviction with ev_ready toggled 1,0,0,1,…:
  - 8 words emitted in order; ev_data stable during stalls.
  - ev_last only on offset 7; no word lost or duplicated.
- Simultaneous starts:
  - fill_start and ev_start in the same cycle → EVICT only; no fill_ready; fill_done never pulses.
- Async reset mid-EVICT (after 3 words):
  - All outputs go to 0 immediately, state IDLE.
  - A later CPU read returns unchanged RAM contents.
